// File: rtl/player_ctrl_pkg.sv
// rtl/player_ctrl_pkg.sv - shared state encoding, button codes and playfield defaults
package player_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] BTN_U = 4'd8;
  localparam logic [3:0] BTN_D = 4'd4;
  localparam logic [3:0] BTN_R = 4'd2;
  localparam logic [3:0] BTN_L = 4'd1;

  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_PLAYER_SIZE = 12;

  // Only one-hot codes are requests; 0 and chords are ignored.
  function automatic logic btn_valid(input logic [3:0] b);
    return (b == BTN_U) || (b == BTN_D) || (b == BTN_R) || (b == BTN_L);
  endfunction

endpackage

// File: rtl/pos_wrap_step.sv
// rtl/pos_wrap_step.sv - combinational one-pixel step with playfield wrap-around
module pos_wrap_step
  import player_ctrl_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int PLAYER_SIZE = DEF_PLAYER_SIZE
) (
  input  logic [31:0] h_pos,
  input  logic [31:0] v_pos,
  input  logic [3:0]  dir,
  output logic [31:0] next_h,
  output logic [31:0] next_v
);

  localparam logic [31:0] H_MAX = 32'(SCREEN_W - PLAYER_SIZE);
  localparam logic [31:0] V_MAX = 32'(SCREEN_H - PLAYER_SIZE);

  always_comb begin
    next_h = h_pos;
    next_v = v_pos;
    case (dir)
      BTN_U:   next_v = (v_pos == 32'd0) ? V_MAX : v_pos - 32'd1;
      BTN_D:   next_v = (v_pos == V_MAX) ? 32'd0 : v_pos + 32'd1;
      BTN_L:   next_h = (h_pos == 32'd0) ? H_MAX : h_pos - 32'd1;
      BTN_R:   next_h = (h_pos == H_MAX) ? 32'd0 : h_pos + 32'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - player position/colour owner gating moves on rectangle enables; BLOCKED_CNT_EN adds blocked_cnt
module player_move_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int N_RECT      = 4,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int PLAYER_SIZE = DEF_PLAYER_SIZE,
  parameter int REPEAT_DIV  = 8
) (
  input  logic              btnClk,
  input  logic              rst,
  input  logic [3:0]        btns,
  input  logic              color_btn,
  input  logic [N_RECT-1:0] up_en_vec,
  input  logic [N_RECT-1:0] down_en_vec,
  input  logic [N_RECT-1:0] left_en_vec,
  input  logic [N_RECT-1:0] right_en_vec,
  output logic [31:0]       player_hPos,
  output logic [31:0]       player_vPos,
  output logic [3:0]        player_color,
  output logic              moving,
  output logic              blocked
`ifdef BLOCKED_CNT_EN
  ,
  output logic [15:0]       blocked_cnt
`endif
);

  localparam int          CW      = $clog2(REPEAT_DIV);
  localparam logic [31:0] H_START = 32'((SCREEN_W - PLAYER_SIZE) / 2);
  localparam logic [31:0] V_START = 32'((SCREEN_H - PLAYER_SIZE) / 2);

  state_t        state, next_state;
  logic [3:0]    dir;
  logic [CW-1:0] hold_cnt;
  logic          allow, step_en, req_valid, color_q;
  logic [31:0]   next_h, next_v;

  assign req_valid = btn_valid(btns);

  always_comb begin
    allow = 1'b0;
    case (dir)
      BTN_U:   allow = &up_en_vec;
      BTN_D:   allow = &down_en_vec;
      BTN_L:   allow = &left_en_vec;
      BTN_R:   allow = &right_en_vec;
      default: allow = 1'b0;
    endcase
  end

  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = SETTLE;
      SETTLE:  next_state = CHECK;
      CHECK:   next_state = HOLD;
      HOLD: begin
        if (btns != dir)          next_state = IDLE;
        else if (hold_cnt == '0)  next_state = SETTLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    moving  = (state != IDLE);
    blocked = (state == CHECK) && !allow;
    step_en = (state == CHECK) && allow;
  end

  pos_wrap_step #(
    .SCREEN_W    (SCREEN_W),
    .SCREEN_H    (SCREEN_H),
    .PLAYER_SIZE (PLAYER_SIZE)
  ) u_step (
    .h_pos  (player_hPos),
    .v_pos  (player_vPos),
    .dir    (dir),
    .next_h (next_h),
    .next_v (next_v)
  );

  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst) begin
      dir         <= 4'd0;
      hold_cnt    <= '0;
      player_hPos <= H_START;
      player_vPos <= V_START;
    end else begin
      if (state == IDLE && req_valid) dir <= btns;
      if (state == CHECK)                          hold_cnt <= CW'(REPEAT_DIV - 1);
      else if (state == HOLD && hold_cnt != '0)    hold_cnt <= hold_cnt - 1'b1;
      if (step_en) begin
        player_hPos <= next_h;
        player_vPos <= next_v;
      end
    end
  end

  // Colour advances on a registered rising edge, independent of the move FSM.
  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst) begin
      color_q      <= 1'b0;
      player_color <= 4'd1;
    end else begin
      color_q <= color_btn;
      if (color_btn && !color_q) player_color <= player_color + 4'd1;
    end
  end

`ifdef BLOCKED_CNT_EN
  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst)                                blocked_cnt <= 16'd0;
    else if (blocked && blocked_cnt != 16'hFFFF) blocked_cnt <= blocked_cnt + 16'd1;
  end
`endif

endmodule
